fir_axis_src: RTL and testbench

AXI4-Stream packet source that drives the FIR chain's slave stream input with deterministic test samples. On a start pulse it emits a programmable number of packets, each NUM_OF_SAMPLES beats long, terminated by TLAST, with an optional idle gap between packets. It is the transmit end of the stream that the FIR top level receives. It is used for on-chip BIST stimulus and as a bench driver.

---
 rtl/fir_axis_src_if.sv | 12 +
 rtl/fir_axis_src.sv | 146 ++++++++++++++
 tb/tb_fir_axis_src.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_axis_src_if.sv
// AXI4-Stream link between fir_axis_src (master) and the FIR chain input (slave).
interface fir_axis_src_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] TDATA;
    logic                  TLAST;
    logic                  TVALID;
    logic                  TREADY;

    modport master (output TDATA, output TLAST, output TVALID, input TREADY);
    modport slave  (input TDATA, input TLAST, input TVALID, output TREADY);
endinterface

// File: rtl/fir_axis_src.sv
// Deterministic AXI4-Stream packet source: ramp samples by default, 16-bit LFSR
// samples when FIR_SRC_LFSR_EN is defined (DATA_WIDTH must then be 16).
module fir_axis_src #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_OF_SAMPLES = 2000,
    parameter int IDLE_CYCLES    = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [15:0]           PKT_COUNT,
    input  logic [DATA_WIDTH-1:0] SEED,
    output logic                  BUSY,
    output logic                  DONE,
    fir_axis_src_if.master        M_AXIS
);
    localparam int BW = $clog2(NUM_OF_SAMPLES + 1);
    localparam int GW = $clog2(IDLE_CYCLES + 2);
    localparam logic FIRST_LAST = (NUM_OF_SAMPLES == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_FINISH
    } state_t;

    state_t                state_q;
    logic [BW-1:0]         beat_q;
    logic [15:0]           pkt_q;
    logic [15:0]           pkt_cnt_q;
    logic [GW-1:0]         gap_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tlast_q;
    logic                  tvalid_q;
    logic                  busy_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] sample_d;
    logic [DATA_WIDTH-1:0] seed_d;
    logic                  hs;
    logic                  more_pkts;

`ifdef FIR_SRC_LFSR_EN
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1; zero would lock up.
    logic fb;
    always_comb begin
        fb       = tdata_q[0] ^ tdata_q[2] ^ tdata_q[3] ^ tdata_q[5];
        sample_d = {fb, tdata_q[DATA_WIDTH-1:1]};
        seed_d   = (SEED == '0) ? DATA_WIDTH'(16'hACE1) : SEED;
    end
`else
    always_comb begin
        sample_d = tdata_q + DATA_WIDTH'(1);
        seed_d   = SEED;
    end
`endif

    assign hs        = tvalid_q & M_AXIS.TREADY;
    assign more_pkts = (pkt_q + 16'd1) != pkt_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            pkt_q     <= '0;
            pkt_cnt_q <= '0;
            gap_q     <= '0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        busy_q <= 1'b1;
                        if (PKT_COUNT != 16'd0) begin
                            pkt_cnt_q <= PKT_COUNT;
                            pkt_q     <= '0;
                            beat_q    <= '0;
                            tdata_q   <= seed_d;
                            tlast_q   <= FIRST_LAST;
                            tvalid_q  <= 1'b1;
                            state_q   <= S_SEND;
                        end else begin
                            state_q   <= S_FINISH;
                        end
                    end
                end
                S_SEND: begin
                    if (hs) begin
                        tdata_q <= sample_d;
                        if (tlast_q) begin
                            beat_q  <= '0;
                            if (more_pkts) begin
                                pkt_q   <= pkt_q + 16'd1;
                                tlast_q <= FIRST_LAST;
                                if (IDLE_CYCLES != 0) begin
                                    tvalid_q <= 1'b0;
                                    gap_q    <= GW'(IDLE_CYCLES - 1);
                                    state_q  <= S_GAP;
                                end
                            end else begin
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                done_q   <= 1'b1;
                                state_q  <= S_FINISH;
                            end
                        end else begin
                            beat_q  <= beat_q + BW'(1);
                            tlast_q <= (beat_q + BW'(1)) == BW'(NUM_OF_SAMPLES - 1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        tvalid_q <= 1'b1;
                        state_q  <= S_SEND;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                S_FINISH: begin
                    // Entered with DONE already set after a real run; an empty run sets it here.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign M_AXIS.TDATA  = tdata_q;
    assign M_AXIS.TLAST  = tlast_q;
    assign M_AXIS.TVALID = tvalid_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
endmodule

// File: tb/tb_fir_axis_src.sv
// Bench for fir_axis_src with 8-beat packets and 4-cycle gaps.
module tb_fir_axis_src;
    localparam int NS = 8;
    localparam int IG = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [15:0] PKT_COUNT;
    logic [15:0] SEED;
    logic        BUSY;
    logic        DONE;

    int checks   = 0;
    int failures = 0;

    logic [15:0] got_d[$];
    logic        got_l[$];

    fir_axis_src_if #(.DATA_WIDTH(16)) axis ();

    fir_axis_src #(
        .DATA_WIDTH(16),
        .NUM_OF_SAMPLES(NS),
        .IDLE_CYCLES(IG)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .START(START),
        .PKT_COUNT(PKT_COUNT),
        .SEED(SEED),
        .BUSY(BUSY),
        .DONE(DONE),
        .M_AXIS(axis)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] model_sample(input logic [15:0] seed, input int k);
        logic [15:0] s;
`ifdef FIR_SRC_LFSR_EN
        s = (seed == 16'd0) ? 16'hACE1 : seed;
        for (int i = 0; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
`else
        s = seed + 16'(k);
`endif
        return s;
    endfunction

    // mode: 0 ready always, 1 random ready, 2 repeating 1,0,0,1; poke pulses START mid-run
    task automatic run_check(input logic [15:0] seed, input logic [15:0] pkts,
                             input int mode, input bit poke, input string name);
        logic [15:0] exp_d[$];
        logic        exp_l[$];
        int cyc, last_hs, done_cyc, in_pkt, low_run, exp_done, n;
        bit after_last, prev_stall;
        logic [15:0] d, pd;
        logic v, l, pl, r;
        for (int k = 0; k < int'(pkts) * NS; k++) begin
            exp_d.push_back(model_sample(seed, k));
            exp_l.push_back((k % NS) == NS - 1);
        end
        got_d.delete();
        got_l.delete();
        START = 1'b1; PKT_COUNT = pkts; SEED = seed;
        @(posedge CLK); #1;
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1) begin failures++; $display("FAIL %s start_busy got=%b want=1", name, BUSY); end
        checks++;
        if (axis.TVALID !== (pkts != 16'd0)) begin
            failures++; $display("FAIL %s start_valid got=%b want=%b", name, axis.TVALID, pkts != 16'd0);
        end
        cyc = 0; last_hs = -1; done_cyc = -1; in_pkt = 0; low_run = 0;
        after_last = 0; prev_stall = 0; pd = '0; pl = 1'b0;
        while (done_cyc < 0 && cyc < 400) begin
            v = axis.TVALID; d = axis.TDATA; l = axis.TLAST;
            if (prev_stall) begin
                checks++;
                if (v !== 1'b1 || d !== pd || l !== pl) begin
                    failures++;
                    $display("FAIL %s stall_hold cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", name, cyc, v, d, l, pd, pl);
                end
            end
            if (DONE === 1'b1) begin
                done_cyc = cyc;
                checks++;
                if (v !== 1'b0) begin failures++; $display("FAIL %s done_valid got=%b want=0", name, v); end
            end else begin
                checks++;
                if (BUSY !== 1'b1) begin failures++; $display("FAIL %s busy_high cyc=%0d got=%b want=1", name, cyc, BUSY); end
            end
            if (in_pkt != 0) begin
                checks++;
                if (v !== 1'b1) begin failures++; $display("FAIL %s valid_drop cyc=%0d got=%b want=1", name, cyc, v); end
            end
            if (v === 1'b1 && after_last) begin
                checks++;
                if (low_run != IG) begin failures++; $display("FAIL %s gap_len got=%0d want=%0d", name, low_run, IG); end
                after_last = 0;
            end
            low_run = (v === 1'b1) ? 0 : low_run + 1;
            case (mode)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: r = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            axis.TREADY = r;
            if (poke && cyc == 5) begin
                START = 1'b1; PKT_COUNT = pkts + 16'd1; SEED = ~seed;
            end else begin
                START = 1'b0;
            end
            if (v === 1'b1 && r) begin
                got_d.push_back(d);
                got_l.push_back(l);
                prev_stall = 0;
                in_pkt++;
                if (in_pkt == NS) begin in_pkt = 0; after_last = 1; last_hs = cyc; end
            end else begin
                prev_stall = (v === 1'b1) && !r;
            end
            pd = d; pl = l;
            @(posedge CLK); #1;
            cyc++;
        end
        START = 1'b0;
        checks++;
        if (done_cyc < 0) begin
            failures++; $display("FAIL %s timeout got=no_done want=done", name);
        end else begin
            exp_done = (pkts == 16'd0) ? 1 : last_hs + 1;
            checks++;
            if (done_cyc != exp_done) begin failures++; $display("FAIL %s done_time got=%0d want=%0d", name, done_cyc, exp_done); end
        end
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            failures++; $display("FAIL %s after_done got done=%b busy=%b want done=0 busy=0", name, DONE, BUSY);
        end
        checks++;
        if (got_d.size() != exp_d.size()) begin
            failures++; $display("FAIL %s beat_count got=%0d want=%0d", name, got_d.size(), exp_d.size());
        end
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k]) begin
                failures++;
                $display("FAIL %s beat%0d got d=%h l=%b want d=%h l=%b", name, k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; START = 1'b0; PKT_COUNT = '0; SEED = '0; axis.TREADY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (axis.TVALID !== 1'b0 || axis.TLAST !== 1'b0 || axis.TDATA !== 16'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got v=%b l=%b d=%h busy=%b done=%b want all 0",
                     axis.TVALID, axis.TLAST, axis.TDATA, BUSY, DONE);
        end
        RESET = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_single_packet();
        run_check(16'h0010, 16'd1, 0, 0, "single");
        if (got_d.size() == NS) begin
            checks++;
            if (got_d[0] !== 16'h0010 || got_d[7] !== 16'h0017 || got_l[7] !== 1'b1) begin
                failures++;
                $display("FAIL single_ends got first=%h last=%h tlast=%b want 0010 0017 1", got_d[0], got_d[7], got_l[7]);
            end
        end
    endtask

    task automatic test_multi_packet();
        run_check(16'h0010, 16'd3, 0, 0, "multi");
        if (got_d.size() == 3 * NS) begin
            checks++;
            if (got_d[8] !== 16'h0018 || got_d[16] !== 16'h0020) begin
                failures++; $display("FAIL multi_cross got %h %h want 0018 0020", got_d[8], got_d[16]);
            end
        end
    endtask

    task automatic test_backpressure();
        run_check(16'h1234, 16'd1, 2, 0, "pattern");
        run_check(16'h0100, 16'd2, 1, 0, "rand_ready");
    endtask

    task automatic test_wrap();
        run_check(16'hFFFE, 16'd1, 0, 0, "wrap");
    endtask

    task automatic test_zero_count();
        run_check(16'h5555, 16'd0, 0, 0, "zero_pkts");
    endtask

    task automatic test_reset_midpacket();
        logic [15:0] s;
        s = 16'($urandom);
        START = 1'b1; PKT_COUNT = 16'd1; SEED = s; axis.TREADY = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (axis.TVALID !== 1'b1 || axis.TDATA !== model_sample(s, 3)) begin
            failures++; $display("FAIL midpkt_beat3 got v=%b d=%h want v=1 d=%h", axis.TVALID, axis.TDATA, model_sample(s, 3));
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        checks++;
        if (axis.TVALID !== 1'b0 || axis.TLAST !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL midpkt_reset got v=%b l=%b busy=%b done=%b want 0 0 0 0", axis.TVALID, axis.TLAST, BUSY, DONE);
        end
        run_check(s ^ 16'h00F0, 16'd1, 0, 0, "restart");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_check(16'($urandom), 16'($urandom_range(1, 3)), 1, (i % 2) == 1, "random");
        end
    endtask

`ifdef FIR_SRC_LFSR_EN
    task automatic test_lfsr();
        run_check(16'h0000, 16'd1, 0, 0, "lfsr");
        if (got_d.size() >= 2) begin
            checks++;
            if (got_d[0] !== 16'hACE1 || got_d[1] !== 16'h5670) begin
                failures++; $display("FAIL lfsr_first got %h %h want ACE1 5670", got_d[0], got_d[1]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef FIR_SRC_LFSR_EN
        test_lfsr();
        test_backpressure();
        test_zero_count();
        test_reset_midpacket();
        test_random();
`else
        test_single_packet();
        test_multi_packet();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_reset_midpacket();
        test_random();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
